// File: rtl/hit_event_gen_if.sv
// rtl/hit_event_gen_if.sv - hit event stream handshake between generator and readout
interface hit_event_gen_if #(
  parameter int DATA_W = 22
);
  logic              hit_valid;
  logic              hit_ready;
  logic [DATA_W-1:0] hit_data;

  modport master (output hit_valid, output hit_data, input hit_ready);
  modport slave  (input hit_valid, input hit_data, output hit_ready);
endinterface

// File: rtl/hit_event_gen.sv
// rtl/hit_event_gen.sv - threshold hit generator with dead time and FWFT event FIFO
// Optional hit/drop statistics counters when HIT_GEN_STATS_EN is defined.
module hit_event_gen #(
  parameter int RAND_W   = 7,
  parameter int CH_W     = 6,
  parameter int TS_W     = 16,
  parameter int FIFO_AW  = 3,
  parameter int DEAD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [RAND_W-1:0] rand_in,
  input  logic [CH_W-1:0]   rand_ch,
  input  logic [RAND_W-1:0] occ_thresh,
  hit_event_gen_if.master   hs,
  output logic              fifo_full,
  output logic              overflow,
  output logic              busy
`ifdef HIT_GEN_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [15:0]       drop_count
`endif
);
  localparam int DATA_W = TS_W + CH_W;
  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int DCNT_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LOAD = DCNT_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, LIVE, DEAD} state_t;

  state_t             state, state_nxt;
  logic [DCNT_W-1:0]  dead_cnt, dead_cnt_nxt;
  logic               hit_det;
  logic [TS_W-1:0]    ts;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               fifo_empty, pop, drop, wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dead_cnt <= '0;
    end else begin
      state    <= state_nxt;
      dead_cnt <= dead_cnt_nxt;
    end
  end

  // dead_cnt counts down from DEAD_CYC-1 so DEAD lasts exactly DEAD_CYC edges
  always_comb begin
    state_nxt    = state;
    dead_cnt_nxt = dead_cnt;
    hit_det      = 1'b0;
    if (!enable) begin
      state_nxt    = IDLE;
      dead_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: state_nxt = LIVE;
        LIVE: begin
          if (rand_in < occ_thresh) begin
            hit_det = 1'b1;
            if (DEAD_CYC > 0) begin
              state_nxt    = DEAD;
              dead_cnt_nxt = DCNT_LOAD;
            end
          end
        end
        DEAD: begin
          if (dead_cnt == '0) state_nxt = LIVE;
          else                dead_cnt_nxt = dead_cnt - DCNT_W'(1);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         ts <= '0;
    else if (enable) ts <= ts + TS_W'(1);
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = count[FIFO_AW];
  assign pop        = !fifo_empty && hs.hit_ready;
  // A simultaneous pop frees the slot, so a full FIFO only drops without one
  assign drop       = hit_det && fifo_full && !pop;
  assign wr_en      = hit_det && !drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)   rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ts, rand_ch};
  end

  assign hs.hit_valid = !fifo_empty;
  assign hs.hit_data  = fifo_empty ? '0 : mem[rd_ptr];
  assign busy         = (state != IDLE) || !fifo_empty;

`ifdef HIT_GEN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      drop_count <= '0;
    end else begin
      if (hit_det && (hit_count != '1)) hit_count  <= hit_count + 32'd1;
      if (drop && (drop_count != '1))   drop_count <= drop_count + 16'd1;
    end
  end
`endif
endmodule
